// File: rtl/uart_tx_peri.sv
// uart_tx_peri: memory-mapped UART transmitter (8N1) on the core's data bus.
//
// CPU stores to TXDATA push bytes into a small TX FIFO. A bit-timed FSM drains
// the FIFO and serialises each byte as an 8N1 frame on tx, LSB first. Loads
// return TX status or the baud divider combinationally, with no side effects.
//
// Register map (word offset A[4:2], A[1:0] ignored):
//   0 TXDATA   W: push WD[7:0]                      R: 0
//   1 STATUS   W: WD[3]=1 clears ovf                R: {24'b0, level[3:0], ovf, busy, empty, full}
//   2 BAUD_DIV W: WD[15:0]                          R: {16'b0, baud_div}
//   3..7       W: ignored                           R: 0
//
// Ports:
//   clk  in   1   system clock, all state on rising edge
//   rst  in   1   asynchronous, active-high reset
//   A    in   5   byte address from core
//   WD   in   32  store data
//   WE   in   1   store strobe
//   RD   out  32  load data, combinational from A and current state
//   tx   out  1   registered serial output, idles high
//
// Bit period is BAUD_DIV+1 clocks; a frame is 10 bit periods.

module uart_tx_peri #(
  parameter int unsigned FIFO_DEPTH  = 4,   // power of 2, 2..8
  parameter int unsigned DEFAULT_DIV = 867  // 115200 baud at 100 MHz
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  A,
  input  logic [31:0] WD,
  input  logic        WE,
  output logic [31:0] RD,
  output logic        tx
);

  localparam int unsigned PtrW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [3:0]  DepthLvl   = 4'(FIFO_DEPTH);
  localparam logic [15:0] DefaultDiv = 16'(DEFAULT_DIV);

  localparam logic [2:0] OffTxData = 3'd0;
  localparam logic [2:0] OffStatus = 3'd1;
  localparam logic [2:0] OffBaud   = 3'd2;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } state_e;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic [2:0] off;
  logic       unused_bus;

  assign off        = A[4:2];
  assign unused_bus = ^{A[1:0], WD[31:16]};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e          state_q, state_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic [15:0]     baud_q, baud_d;
  logic            ovf_q, ovf_d;
  logic [3:0]      level_q, level_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]      fifo_q [FIFO_DEPTH];

  logic full, empty, busy;
  logic push, pop;
  logic bit_end;
  logic [7:0] fifo_head;

  assign full      = (level_q == DepthLvl);
  assign empty     = (level_q == 4'd0);
  assign busy      = (state_q != StIdle);
  assign bit_end   = (cnt_q == 16'd0);
  assign fifo_head = fifo_q[rd_ptr_q];

  // Full is judged on the pre-edge level, so a simultaneous pop never rescues a push.
  assign push = WE && (off == OffTxData) && !full;

  // ---------------------------------------------------------------------------
  // Control registers and FIFO bookkeeping
  // ---------------------------------------------------------------------------
  always_comb begin
    baud_d   = baud_q;
    ovf_d    = ovf_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;

    if (WE && (off == OffBaud)) begin
      baud_d = WD[15:0];
    end

    if (WE && (off == OffTxData) && full) begin
      ovf_d = 1'b1;
    end else if (WE && (off == OffStatus) && WD[3]) begin
      ovf_d = 1'b0;
    end

    // Pointer width equals log2(depth), so the increment wraps naturally.
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    unique case ({push, pop})
      2'b10:   level_d = level_q + 4'd1;
      2'b01:   level_d = level_q - 4'd1;
      default: level_d = level_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM next-state: bit timing, shift register and FIFO pop
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = fifo_head;
          cnt_d   = baud_q;
          state_d = StStart;
        end
      end

      StStart: begin
        if (bit_end) begin
          cnt_d     = baud_q;
          bit_idx_d = 3'd0;
          state_d   = StData;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end

      StData: begin
        if (bit_end) begin
          cnt_d   = baud_q;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end

      StStop: begin
        if (bit_end) begin
          // Chain straight into the next frame when more data is queued.
          if (!empty) begin
            pop     = 1'b1;
            shift_d = fifo_head;
            cnt_d   = baud_q;
            state_d = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM output: tx is registered from the next state so it changes on the
  // same edge that enters a state.
  // ---------------------------------------------------------------------------
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= 16'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      tx_q      <= 1'b1;
      baud_q    <= DefaultDiv;
      ovf_q     <= 1'b0;
      level_q   <= 4'd0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      baud_q    <= baud_d;
      ovf_q     <= ovf_d;
      level_q   <= level_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  // FIFO storage carries no reset; entries are only read when level says valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= WD[7:0];
    end
  end

  assign tx = tx_q;

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  always_comb begin
    RD = 32'd0;
    case (off)
      OffStatus: RD = {24'd0, level_q, ovf_q, busy, empty, full};
      OffBaud:   RD = {16'd0, baud_q};
      default:   RD = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_peri.sv
// Directed bench for uart_tx_peri: register reads, frame timing, FIFO fill and
// overflow, back-to-back frames, mid-frame baud change and mid-frame reset.

module tb_uart_tx_peri;

  logic        clk;
  logic        rst;
  logic [4:0]  A;
  logic [31:0] WD;
  logic        WE;
  logic [31:0] RD;
  logic        tx;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_peri #(
    .FIFO_DEPTH (4),
    .DEFAULT_DIV(867)
  ) dut (
    .clk(clk),
    .rst(rst),
    .A  (A),
    .WD (WD),
    .WE (WE),
    .RD (RD),
    .tx (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic bus_write(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clk);
    A  = addr;
    WD = data;
    WE = 1'b1;
    @(negedge clk);
    WE = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    A = addr;
    #1;
    check_eq(tag, RD, exp);
  endtask

  // Samples tx once per clock for a whole frame. The first n_a bit periods last
  // div_a+1 clocks, the rest div_b+1. Call at the negedge before the START edge.
  task automatic expect_frame(input logic [7:0] b, input int div_a, input int div_b,
                              input int n_a);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      int len;
      len = (i < n_a) ? div_a + 1 : div_b + 1;
      for (int c = 0; c < len; c++) begin
        @(negedge clk);
        check_eq($sformatf("tx byte %02h bit %0d cyc %0d", b, i, c), {31'd0, tx},
                 {31'd0, f[i]});
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] burst [6];
    burst[0] = 8'h11; burst[1] = 8'h22; burst[2] = 8'h33;
    burst[3] = 8'h44; burst[4] = 8'h5A; burst[5] = 8'hEE;

    rst = 1'b1;
    A   = 5'd0;
    WD  = 32'd0;
    WE  = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("tx in reset", {31'd0, tx}, 32'd1);
    rst = 1'b0;

    // 1. Reset register values and decode
    @(negedge clk);
    rd_check("txdata reads 0", 5'd0, 32'd0);
    rd_check("status reset", 5'd4, 32'h02);
    rd_check("baud reset", 5'd8, 32'd867);
    rd_check("A[1:0] ignored", 5'd5, 32'h02);
    check_eq("tx idle", {31'd0, tx}, 32'd1);
    bus_write(5'd12, 32'hFFFF_FFFF);
    rd_check("offset 3 reads 0", 5'd12, 32'd0);
    rd_check("offset 3 write ignored", 5'd4, 32'h02);
    rd_check("offset 7 reads 0", 5'd28, 32'd0);
    bus_write(5'd8, 32'hABCD_0003);
    rd_check("baud zero-ext", 5'd8, 32'd3);

    // 2. Single frame at BAUD_DIV=3
    bus_write(5'd0, 32'h0000_00A5);
    rd_check("t2 queued", 5'd4, 32'h10);
    check_eq("t2 tx before pop", {31'd0, tx}, 32'd1);
    expect_frame(8'hA5, 3, 3, 10);
    rd_check("t2 busy last cyc", 5'd4, 32'h06);
    @(negedge clk);
    rd_check("t2 idle after", 5'd4, 32'h02);

    // 3. BAUD_DIV=0, fill FIFO, overflow, contiguous frames
    bus_write(5'd8, 32'd0);
    @(negedge clk);
    A  = 5'd0;
    WD = {24'd0, burst[0]};
    WE = 1'b1;
    fork
      begin
        for (int i = 1; i < 5; i++) begin
          @(negedge clk);
          WD = {24'd0, burst[i]};
        end
        @(negedge clk);
        A = 5'd4;
        #1;
        check_eq("t3 full", RD, 32'h45);
        A  = 5'd0;
        WD = {24'd0, burst[5]};
        @(negedge clk);
        WE = 1'b0;
        A  = 5'd4;
        #1;
        check_eq("t3 ovf", RD, 32'h4D);
      end
      begin
        @(negedge clk);
        for (int f = 0; f < 5; f++) expect_frame(burst[f], 0, 0, 10);
      end
    join
    rd_check("t3 last stop", 5'd4, 32'h0E);
    @(negedge clk);
    rd_check("t3 idle ovf", 5'd4, 32'h0A);
    bus_write(5'd4, 32'h8);
    rd_check("t3 ovf clear", 5'd4, 32'h02);

    // 4. Second byte written during first DATA, frames chain
    bus_write(5'd8, 32'd1);
    bus_write(5'd0, 32'h55);
    fork
      begin
        expect_frame(8'h55, 1, 1, 10);
        expect_frame(8'h0F, 1, 1, 10);
      end
      begin
        repeat (3) @(negedge clk);
        bus_write(5'd0, 32'h0F);
        A = 5'd4;
        repeat (15) @(negedge clk);
        #1;
        check_eq("t4 stop queued", RD, 32'h14);
        @(negedge clk);
        #1;
        check_eq("t4 second pop", RD, 32'h06);
      end
    join
    @(negedge clk);
    rd_check("t4 idle", 5'd4, 32'h02);

    // 5. Mid-DATA baud change applies at next reload
    bus_write(5'd8, 32'd7);
    bus_write(5'd0, 32'h3C);
    fork
      expect_frame(8'h3C, 7, 1, 2);
      begin
        repeat (10) @(negedge clk);
        bus_write(5'd8, 32'd1);
      end
    join
    rd_check("t5 baud", 5'd8, 32'd1);
    @(negedge clk);
    rd_check("t5 idle", 5'd4, 32'h02);

    // 6. Reset mid-DATA
    bus_write(5'd8, 32'd3);
    bus_write(5'd0, 32'hA4);
    repeat (8) @(negedge clk);
    check_eq("t6 tx data bit", {31'd0, tx}, 32'd0);
    rst = 1'b1;
    #1;
    check_eq("t6 tx on reset", {31'd0, tx}, 32'd1);
    rd_check("t6 status", 5'd4, 32'h02);
    rd_check("t6 baud", 5'd8, 32'd867);
    @(negedge clk);
    rst = 1'b0;
    bus_write(5'd8, 32'd2);
    bus_write(5'd0, 32'h96);
    expect_frame(8'h96, 2, 2, 10);
    @(negedge clk);
    rd_check("t6 idle", 5'd4, 32'h02);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
